// File: rtl/rvm_irq_ctrl_pkg.sv
// Shared constants for the machine-mode interrupt/timer controller:
// register word indexes, cause codes and handshake FSM states.
package rvm_irq_ctrl_pkg;

    localparam logic [3:0] REG_PENDING     = 4'd0;
    localparam logic [3:0] REG_ENABLE      = 4'd1;
    localparam logic [3:0] REG_CLAIM       = 4'd2;
    localparam logic [3:0] REG_PRESCALE    = 4'd3;
    localparam logic [3:0] REG_MTIME_LO    = 4'd4;
    localparam logic [3:0] REG_MTIME_HI    = 4'd5;
    localparam logic [3:0] REG_MTIMECMP_LO = 4'd6;
    localparam logic [3:0] REG_MTIMECMP_HI = 4'd7;
    localparam logic [3:0] REG_CTRL        = 4'd8;

    localparam logic [4:0] CAUSE_NONE  = 5'd0;
    localparam logic [4:0] CAUSE_TIMER = 5'd31;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } irq_state_e;

    function automatic logic [4:0] chan_cause(input int idx);
        return 5'(idx + 1);
    endfunction

endpackage

// File: rtl/rvm_irq_ctrl_if.sv
// Register port and trap-sequencer handshake between the CSR/core side
// (master) and the interrupt controller (slave).
interface rvm_irq_ctrl_if;

    logic [3:0]  reg_addr;
    logic        reg_wen;
    logic [31:0] reg_wdata;
    logic [31:0] reg_rdata;
    logic        core_stall;
    logic        irq_req;
    logic [4:0]  irq_cause;
    logic        irq_ack;
    logic        irq_done;

    modport master (
        output reg_addr, reg_wen, reg_wdata, core_stall, irq_ack, irq_done,
        input  reg_rdata, irq_req, irq_cause
    );

    modport slave (
        input  reg_addr, reg_wen, reg_wdata, core_stall, irq_ack, irq_done,
        output reg_rdata, irq_req, irq_cause
    );

endinterface

// File: rtl/rvm_irq_ctrl_timer.sv
// Prescaled mtime counter with mtimecmp and a registered mtip compare.
module rvm_irq_timer #(
    parameter int TIMER_W    = 64,
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  te_i,
    input  logic [PRESCALE_W-1:0] prescale_i,
    input  logic                  wr_mtime_lo_i,
    input  logic                  wr_mtime_hi_i,
    input  logic                  wr_cmp_lo_i,
    input  logic                  wr_cmp_hi_i,
    input  logic [31:0]           wdata_i,
    output logic [TIMER_W-1:0]    mtime_o,
    output logic [TIMER_W-1:0]    mtimecmp_o,
    output logic                  mtip_o
);

    logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
    logic [TIMER_W-1:0]    mtime_q, mtime_d;
    logic [TIMER_W-1:0]    cmp_q, cmp_d;
    logic                  mtip_q;
    logic                  tick_s;

    // A counter left above a newly lowered PRESCALE also wraps instead of running to all ones.
    always_comb begin
        pcnt_d = pcnt_q;
        tick_s = 1'b0;
        if (te_i) begin
            if (pcnt_q >= prescale_i) begin
                pcnt_d = '0;
                tick_s = 1'b1;
            end else begin
                pcnt_d = pcnt_q + PRESCALE_W'(1'b1);
            end
        end else begin
            pcnt_d = pcnt_q;
        end

        if (wr_mtime_lo_i) begin
            mtime_d = {mtime_q[TIMER_W-1:32], wdata_i};
        end else if (wr_mtime_hi_i) begin
            mtime_d = {wdata_i[TIMER_W-33:0], mtime_q[31:0]};
        end else if (tick_s) begin
            mtime_d = mtime_q + TIMER_W'(1'b1);
        end else begin
            mtime_d = mtime_q;
        end

        if (wr_cmp_lo_i) begin
            cmp_d = {cmp_q[TIMER_W-1:32], wdata_i};
        end else if (wr_cmp_hi_i) begin
            cmp_d = {wdata_i[TIMER_W-33:0], cmp_q[31:0]};
        end else begin
            cmp_d = cmp_q;
        end
    end

    // Timer state and the pipelined compare.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt_q  <= '0;
            mtime_q <= '0;
            cmp_q   <= '1;
            mtip_q  <= 1'b0;
        end else begin
            pcnt_q  <= pcnt_d;
            mtime_q <= mtime_d;
            cmp_q   <= cmp_d;
            mtip_q  <= (mtime_q >= cmp_q);
        end
    end

    assign mtime_o    = mtime_q;
    assign mtimecmp_o = cmp_q;
    assign mtip_o     = mtip_q;

endmodule

// File: rtl/rvm_irq_ctrl.sv
// Machine-mode interrupt controller: NUM_IRQ edge/level channels plus timer,
// fixed priority, and a req/ack/done handshake with the trap sequencer.
module rvm_irq_ctrl
    import rvm_irq_ctrl_pkg::*;
#(
    parameter int                 NUM_IRQ       = 8,
    parameter logic [NUM_IRQ-1:0] IRQ_EDGE_MASK = '0,
    parameter int                 TIMER_W       = 64,
    parameter int                 PRESCALE_W    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_in_i,
    output logic               mtip_o,
    rvm_irq_ctrl_if.slave      bus
);

    irq_state_e            state_q, state_d;
    logic [4:0]            claim_q, claim_d;
    logic                  req_q, req_d;
    logic [NUM_IRQ-1:0]    irq_hist_q, pend_q, pend_d, en_q, en_d;
    logic [NUM_IRQ-1:0]    set_s, clr_s, ack_vec_s;
    logic [2:0]            ctrl_q, ctrl_d;
    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic [TIMER_W-1:0]    mtime_s, mtimecmp_s;
    logic                  mtip_s, ack_clr_s;
    logic [4:0]            cand_s;

    logic wr_pend_s, wr_en_s, wr_presc_s, wr_ctrl_s;
    assign wr_pend_s  = bus.reg_wen && (bus.reg_addr == REG_PENDING);
    assign wr_en_s    = bus.reg_wen && (bus.reg_addr == REG_ENABLE);
    assign wr_presc_s = bus.reg_wen && (bus.reg_addr == REG_PRESCALE);
    assign wr_ctrl_s  = bus.reg_wen && (bus.reg_addr == REG_CTRL);

    assign en_d    = wr_en_s    ? bus.reg_wdata[NUM_IRQ-1:0]    : en_q;
    assign presc_d = wr_presc_s ? bus.reg_wdata[PRESCALE_W-1:0] : presc_q;
    assign ctrl_d  = wr_ctrl_s  ? bus.reg_wdata[2:0]            : ctrl_q;

    rvm_irq_timer #(
        .TIMER_W    (TIMER_W),
        .PRESCALE_W (PRESCALE_W)
    ) u_timer (
        .clk           (clk),
        .rst           (rst),
        .te_i          (ctrl_q[1]),
        .prescale_i    (presc_q),
        .wr_mtime_lo_i (bus.reg_wen && (bus.reg_addr == REG_MTIME_LO)),
        .wr_mtime_hi_i (bus.reg_wen && (bus.reg_addr == REG_MTIME_HI)),
        .wr_cmp_lo_i   (bus.reg_wen && (bus.reg_addr == REG_MTIMECMP_LO)),
        .wr_cmp_hi_i   (bus.reg_wen && (bus.reg_addr == REG_MTIMECMP_HI)),
        .wdata_i       (bus.reg_wdata),
        .mtime_o       (mtime_s),
        .mtimecmp_o    (mtimecmp_s),
        .mtip_o        (mtip_s)
    );

    // Acceptance of the request clears only the claimed edge channel.
    assign ack_clr_s = (state_q == ST_REQ) && bus.irq_ack;
    always_comb begin
        ack_vec_s = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            ack_vec_s[i] = ack_clr_s && (claim_q == chan_cause(i));
        end
    end

    // Edge channels: a new rising edge beats a same-cycle W1C or ack clear.
    assign set_s  = irq_in_i & ~irq_hist_q;
    assign clr_s  = (wr_pend_s ? bus.reg_wdata[NUM_IRQ-1:0] : '0) | ack_vec_s;
    assign pend_d = (~IRQ_EDGE_MASK & irq_in_i)
                  | (IRQ_EDGE_MASK & (set_s | (pend_q & ~clr_s)));

    // Fixed priority: timer first, then the lowest-numbered enabled channel.
    always_comb begin
        cand_s = CAUSE_NONE;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            cand_s = (pend_q[i] && en_q[i]) ? chan_cause(i) : cand_s;
        end
        cand_s = (mtip_s && ctrl_q[2]) ? CAUSE_TIMER : cand_s;
    end

    // Handshake FSM; the cause is latched once and held through REQ and SERVICE.
    always_comb begin
        state_d = state_q;
        claim_d = claim_q;
        req_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ctrl_q[0] && (cand_s != CAUSE_NONE) && !bus.core_stall) begin
                    state_d = ST_REQ;
                    claim_d = cand_s;
                    req_d   = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (bus.irq_ack) begin
                    state_d = ST_SERVICE;
                end else begin
                    state_d = ST_REQ;
                    req_d   = 1'b1;
                end
            end
            ST_SERVICE: begin
                if (bus.irq_done) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_SERVICE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Controller state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            claim_q    <= CAUSE_NONE;
            req_q      <= 1'b0;
            irq_hist_q <= '0;
            pend_q     <= '0;
            en_q       <= '0;
            ctrl_q     <= 3'd0;
            presc_q    <= '0;
        end else begin
            state_q    <= state_d;
            claim_q    <= claim_d;
            req_q      <= req_d;
            irq_hist_q <= irq_in_i;
            pend_q     <= pend_d;
            en_q       <= en_d;
            ctrl_q     <= ctrl_d;
            presc_q    <= presc_d;
        end
    end

    // Register read mux, zero-extended.
    always_comb begin
        case (bus.reg_addr)
            REG_PENDING:     bus.reg_rdata = 32'(pend_q);
            REG_ENABLE:      bus.reg_rdata = 32'(en_q);
            REG_CLAIM:       bus.reg_rdata = 32'(claim_q);
            REG_PRESCALE:    bus.reg_rdata = 32'(presc_q);
            REG_MTIME_LO:    bus.reg_rdata = mtime_s[31:0];
            REG_MTIME_HI:    bus.reg_rdata = 32'(mtime_s[TIMER_W-1:32]);
            REG_MTIMECMP_LO: bus.reg_rdata = mtimecmp_s[31:0];
            REG_MTIMECMP_HI: bus.reg_rdata = 32'(mtimecmp_s[TIMER_W-1:32]);
            REG_CTRL:        bus.reg_rdata = 32'(ctrl_q);
            default:         bus.reg_rdata = 32'd0;
        endcase
    end

    assign bus.irq_req   = req_q;
    assign bus.irq_cause = claim_q;
    assign mtip_o        = mtip_s;

endmodule
